// File: rtl/sc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : sc_frame_packer
// Purpose  : Snapshots N_CHIPS parameter vectors on a start edge and writes
//            them MSB-first as WORD_W-bit words into an external FIFO.
// Revision : 1.0  initial release
// ============================================================================
module sc_frame_packer #(
   parameter int                PARAM_BITS  = 616,
   parameter int                WORD_W      = 8,
   parameter int                N_CHIPS     = 1,
   parameter int                HEADER_EN   = 0,
   parameter logic [WORD_W-1:0] HEADER_WORD = WORD_W'(8'hA5)
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          Start_In,
   input  logic [N_CHIPS*PARAM_BITS-1:0] In_Param,
   input  logic                          In_Fifo_Full,
   output logic                          Out_Ex_Fifo_Wr_En,
   output logic [WORD_W-1:0]             Out_Ex_Fifo_Din,
   output logic                          Busy,
   output logic                          End_Flag,
   output logic [15:0]                   Out_Word_Cnt
);

   localparam int WPC        = (PARAM_BITS + WORD_W - 1) / WORD_W;
   localparam int CHIP_W     = WPC * WORD_W;
   localparam int PAD        = CHIP_W - PARAM_BITS;
   localparam int FRAME_BITS = N_CHIPS * CHIP_W;
   localparam int TOTAL      = HEADER_EN + N_CHIPS * WPC;
   localparam logic [15:0] LAST_IDX = 16'(TOTAL - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2,
      S_END  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    start_dly_q, start_dly_d;
   logic [FRAME_BITS-1:0]   sh_q, sh_d;
   logic [15:0]             cnt_q, cnt_d;
   logic                    wr_q, wr_d;
   logic [WORD_W-1:0]       din_q, din_d;
   logic                    busy_q, busy_d;
   logic                    endf_q, endf_d;
   logic [FRAME_BITS-1:0]   w_snap;
   logic                    w_start;

   // Each chip is left-aligned in its own word-padded slot; chip N_CHIPS-1 lands on top.
   always_comb begin
      w_snap = '0;
      for (int k = 0; k < N_CHIPS; k++) begin
         w_snap[k*CHIP_W + PAD +: PARAM_BITS] = In_Param[k*PARAM_BITS +: PARAM_BITS];
      end
   end

   assign w_start = Start_In & ~start_dly_q;

   always_comb begin
      state_d     = state_q;
      start_dly_d = Start_In;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      wr_d        = 1'b0;
      din_d       = din_q;
      busy_d      = 1'b0;
      endf_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_start) begin
               state_d = S_LOAD;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            sh_d    = w_snap;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            busy_d = 1'b1;
            if (!In_Fifo_Full) begin
               wr_d  = 1'b1;
               cnt_d = cnt_q + 16'd1;
               if (HEADER_EN != 0 && cnt_q == 16'd0) begin
                  din_d = HEADER_WORD;
               end else begin
                  din_d = sh_q[FRAME_BITS-1 -: WORD_W];
                  sh_d  = sh_q << WORD_W;
               end
               if (cnt_q == LAST_IDX) begin
                  state_d = S_END;
               end
            end
         end
         S_END: begin
            busy_d  = 1'b1;
            din_d   = '0;
            endf_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= S_IDLE;
         // Capturing the live level means a Start_In held across reset shows no edge.
         start_dly_q <= Start_In;
         sh_q        <= '0;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         din_q       <= '0;
         busy_q      <= 1'b0;
         endf_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_dly_q <= start_dly_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         din_q       <= din_d;
         busy_q      <= busy_d;
         endf_q      <= endf_d;
      end
   end

   assign Out_Ex_Fifo_Wr_En = wr_q;
   assign Out_Ex_Fifo_Din   = din_q;
   assign Busy              = busy_q;
   assign End_Flag          = endf_q;
   assign Out_Word_Cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_frame_packer
// Purpose  : Self-checking bench for sc_frame_packer (default and 2-chip/header builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_sc_frame_packer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Instance 1: default build (616 bits, one chip, no header)
   logic         start1 = 1'b0, full1 = 1'b0;
   logic [615:0] param1 = '0;
   logic         wr1, busy1, endf1;
   logic [7:0]   din1;
   logic [15:0]  cnt1;

   // Instance 2: 20-bit chips, two chips, header enabled
   logic         start2 = 1'b0, full2 = 1'b0;
   logic [39:0]  param2 = '0;
   logic         wr2, busy2, endf2;
   logic [7:0]   din2;
   logic [15:0]  cnt2;

   sc_frame_packer u_dut1 (
      .Clk(clk), .Rst(rst), .Start_In(start1), .In_Param(param1), .In_Fifo_Full(full1),
      .Out_Ex_Fifo_Wr_En(wr1), .Out_Ex_Fifo_Din(din1), .Busy(busy1), .End_Flag(endf1),
      .Out_Word_Cnt(cnt1));

   sc_frame_packer #(.PARAM_BITS(20), .WORD_W(8), .N_CHIPS(2), .HEADER_EN(1)) u_dut2 (
      .Clk(clk), .Rst(rst), .Start_In(start2), .In_Param(param2), .In_Fifo_Full(full2),
      .Out_Ex_Fifo_Wr_En(wr2), .Out_Ex_Fifo_Din(din2), .Busy(busy2), .End_Flag(endf2),
      .Out_Word_Cnt(cnt2));

   int n_pass = 0;
   int n_total = 0;

   // Output monitors: collect written words and End_Flag events 1 ns after each edge
   int         cyc = 0;
   logic [7:0] obs1[$], obs2[$], exp_q[$];
   int         endc1 = 0, endc2 = 0, end_cyc1 = 0, first_cyc1 = 0, last_cyc1 = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (wr1) begin
         if (obs1.size() == 0) first_cyc1 = cyc;
         obs1.push_back(din1);
         last_cyc1 = cyc;
      end
      if (endf1) begin endc1 = endc1 + 1; end_cyc1 = cyc; end
      if (wr2) obs2.push_back(din2);
      if (endf2) endc2 = endc2 + 1;
   end

   // Reference model: walk the bits of each chip MSB-first, zero-filling past bit 0
   function automatic void build_exp(input logic [615:0] p, input int pb, input int nch, input bit hdr);
      int wpc;
      logic [7:0] wd;
      int idx;
      exp_q.delete();
      if (hdr) exp_q.push_back(8'hA5);
      wpc = (pb + 7) / 8;
      for (int k = nch - 1; k >= 0; k--) begin
         for (int w = 0; w < wpc; w++) begin
            wd = '0;
            for (int b = 0; b < 8; b++) begin
               idx = pb - 1 - (w * 8 + b);
               wd = {wd[6:0], (idx >= 0) ? p[k*pb + idx] : 1'b0};
            end
            exp_q.push_back(wd);
         end
      end
   endfunction

   function automatic logic [615:0] rand616();
      logic [639:0] r = '0;
      for (int i = 0; i < 20; i++) r = {r[607:0], $urandom()};
      return r[615:0];
   endfunction

   task automatic clear_mon();
      obs1.delete(); obs2.delete();
      endc1 = 0; endc2 = 0;
   endtask

   task automatic wait_end1(input int target, input int budget, output bit ok);
      int n = 0;
      while (endc1 < target && n < budget) begin @(negedge clk); n++; end
      ok = (endc1 >= target);
   endtask

   task automatic wait_end2(input int target, input int budget, output bit ok);
      int n = 0;
      while (endc2 < target && n < budget) begin @(negedge clk); n++; end
      ok = (endc2 >= target);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if ({wr1, din1, busy1, endf1, cnt1} !== 27'd0)
         $display("FAIL reset_dut1: outputs=%h required 0", {wr1, din1, busy1, endf1, cnt1});
      else n_pass++;
      n_total++;
      if ({wr2, din2, busy2, endf2, cnt2} !== 27'd0)
         $display("FAIL reset_dut2: outputs=%h required 0", {wr2, din2, busy2, endf2, cnt2});
      else n_pass++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      bit ok;
      int s;
      param1 = rand616();
      build_exp(param1, 616, 1, 1'b0);
      clear_mon();
      @(negedge clk);
      start1 = 1'b1; s = cyc;
      repeat (2) @(negedge clk);
      start1 = 1'b0;
      wait_end1(1, 300, ok);
      n_total++;
      if (!ok) $display("FAIL t1_timeout: end_flags=%0d required 1", endc1); else n_pass++;
      n_total++;
      if (obs1.size() != 77) $display("FAIL t1_count: words=%0d required 77", obs1.size()); else n_pass++;
      for (int i = 0; i < 77 && i < obs1.size(); i++) begin
         n_total++;
         if (obs1[i] !== exp_q[i]) $display("FAIL t1_word%0d: got %h required %h", i, obs1[i], exp_q[i]);
         else n_pass++;
      end
      n_total++;
      if (first_cyc1 != s + 3) $display("FAIL t1_latency: first write edge=%0d required %0d", first_cyc1, s + 3); else n_pass++;
      n_total++;
      if (last_cyc1 - first_cyc1 + 1 != 77) $display("FAIL t1_consecutive: span=%0d required 77", last_cyc1 - first_cyc1 + 1); else n_pass++;
      n_total++;
      if (end_cyc1 != s + 80) $display("FAIL t1_end_edge: end edge=%0d required %0d", end_cyc1, s + 80); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++;
      if (cnt1 !== 16'd77) $display("FAIL t1_word_cnt: got %0d required 77", cnt1); else n_pass++;
      n_total++;
      if (busy1 !== 1'b0 || endf1 !== 1'b0) $display("FAIL t1_idle: busy=%b end=%b required 0 0", busy1, endf1); else n_pass++;
   endtask

   task automatic test_two_chip();
      bit ok;
      logic [7:0] lit[7];
      lit = '{8'hA5, 8'hAB, 8'hCD, 8'hE0, 8'h12, 8'h34, 8'h50};
      for (int rep = 0; rep < 3; rep++) begin
         param2 = (rep == 0) ? 40'hABCDE_12345 : {$urandom(), 8'($urandom())};
         build_exp({576'd0, param2}, 20, 2, 1'b1);
         clear_mon();
         @(negedge clk); start2 = 1'b1;
         @(negedge clk); start2 = 1'b0;
         wait_end2(1, 100, ok);
         n_total++;
         if (!ok || obs2.size() != 7) $display("FAIL t2_count: words=%0d required 7", obs2.size()); else n_pass++;
         for (int i = 0; i < 7 && i < obs2.size(); i++) begin
            n_total++;
            if (obs2[i] !== exp_q[i]) $display("FAIL t2_word%0d: got %h required %h", i, obs2[i], exp_q[i]);
            else n_pass++;
            if (rep == 0) begin
               n_total++;
               if (obs2[i] !== lit[i]) $display("FAIL t2_literal%0d: got %h required %h", i, obs2[i], lit[i]);
               else n_pass++;
            end
         end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int n, stall_wr;
      param2 = {$urandom(), 8'($urandom())};
      build_exp({576'd0, param2}, 20, 2, 1'b1);
      clear_mon();
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      n = 0;
      while (obs2.size() < 3 && n < 50) begin @(negedge clk); n++; end
      full2 = 1'b1;
      stall_wr = 0;
      repeat (5) begin
         @(negedge clk);
         if (wr2 !== 1'b0) stall_wr++;
      end
      full2 = 1'b0;
      n_total++;
      if (stall_wr != 0) $display("FAIL t3_stall_write: writes during stall=%0d required 0", stall_wr); else n_pass++;
      n_total++;
      if (obs2.size() != 3) $display("FAIL t3_stall_hold: words=%0d required 3", obs2.size()); else n_pass++;
      wait_end2(1, 100, ok);
      n_total++;
      if (!ok || obs2 != exp_q) $display("FAIL t3_stream: words=%0d required %0d (content mismatch or timeout)", obs2.size(), exp_q.size());
      else n_pass++;
      // Random stalls over a whole frame
      param2 = {$urandom(), 8'($urandom())};
      build_exp({576'd0, param2}, 20, 2, 1'b1);
      clear_mon();
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      n = 0;
      while (endc2 < 1 && n < 300) begin
         full2 = 1'($urandom_range(0, 1));
         @(negedge clk); n++;
      end
      full2 = 1'b0;
      n_total++;
      if (endc2 != 1 || obs2 != exp_q) $display("FAIL t3_random_stall: words=%0d ends=%0d required %0d 1", obs2.size(), endc2, exp_q.size());
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int n;
      param1 = rand616();
      clear_mon();
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      n = 0;
      while (obs1.size() < 30 && n < 100) begin @(negedge clk); n++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++;
      if ({wr1, din1, busy1, endf1, cnt1} !== 27'd0)
         $display("FAIL t4_reset_outputs: outputs=%h required 0", {wr1, din1, busy1, endf1, cnt1});
      else n_pass++;
      clear_mon();
      repeat (100) @(negedge clk);
      n_total++;
      if (obs1.size() != 0 || endc1 != 0) $display("FAIL t4_abandon: words=%0d ends=%0d required 0 0", obs1.size(), endc1);
      else n_pass++;
      param1 = rand616();
      build_exp(param1, 616, 1, 1'b0);
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      wait_end1(1, 300, ok);
      n_total++;
      if (!ok || obs1 != exp_q) $display("FAIL t4_new_frame: words=%0d ends=%0d required 77 1", obs1.size(), endc1);
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_restart_ignored();
      int n;
      param1 = rand616();
      build_exp(param1, 616, 1, 1'b0);
      clear_mon();
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      n = 0;
      while (obs1.size() < 10 && n < 100) begin @(negedge clk); n++; end
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      // Raise Start_In again exactly in the END cycle
      n = 0;
      while (obs1.size() < 77 && n < 200) begin @(negedge clk); n++; end
      start1 = 1'b1;
      repeat (150) @(negedge clk);
      start1 = 1'b0;
      n_total++;
      if (endc1 != 1 || obs1 != exp_q) $display("FAIL t5_restart: words=%0d ends=%0d required 77 1", obs1.size(), endc1);
      else n_pass++;
      // Start_In held high across reset
      clear_mon();
      @(negedge clk); start1 = 1'b1;
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      repeat (100) @(negedge clk);
      start1 = 1'b0;
      n_total++;
      if (obs1.size() != 0 || endc1 != 0 || busy1 !== 1'b0)
         $display("FAIL t5_held_across_reset: words=%0d ends=%0d busy=%b required 0 0 0", obs1.size(), endc1, busy1);
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_snapshot();
      bit ok;
      int n;
      param1 = rand616();
      param2 = {$urandom(), 8'($urandom())};
      build_exp(param1, 616, 1, 1'b0);
      clear_mon();
      @(negedge clk); start1 = 1'b1; start2 = 1'b1;
      @(negedge clk); start1 = 1'b0; start2 = 1'b0;
      @(negedge clk);
      // Both are past LOAD now; scramble inputs every cycle
      n = 0;
      while ((endc1 < 1 || endc2 < 1) && n < 300) begin
         param1 = ~param1;
         param2 = ~param2;
         @(negedge clk); n++;
      end
      ok = (endc1 == 1);
      n_total++;
      if (!ok || obs1 != exp_q) $display("FAIL t6_snapshot_dut1: words=%0d ends=%0d required 77 1", obs1.size(), endc1);
      else n_pass++;
      // n is even/odd-dependent: param2 has been toggled n times since the snapshot
      if (n % 2 == 1) param2 = ~param2;
      build_exp({576'd0, param2}, 20, 2, 1'b1);
      n_total++;
      if (endc2 != 1 || obs2 != exp_q) $display("FAIL t6_snapshot_dut2: words=%0d ends=%0d required 7 1", obs2.size(), endc2);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_two_chip();
      test_backpressure();
      test_reset_midframe();
      test_restart_ignored();
      test_snapshot();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
